i2c_target: RTL and testbench

- I2C target (slave) responder for the on-board I2C bus; it is the other end of the existing I2C controller used by the display path.
- Lets a second FPGA or a test fixture talk to a module as a 7-bit-addressed device.
- Write bytes from the bus become a byte stream; read bytes are pulled from a byte-source handshake.
- Single clock domain, oversampled SCL/SDA, open-drain SDA drive through o/t pins. No clock stretching.

---
 rtl/i2c_target.sv | 188 ++++++++++++++++++
 tb/tb_i2c_target.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// 7-bit addressed I2C target: oversampled, filtered SCL/SDA, open-drain SDA,
// write bytes out as a pulse stream, read bytes pulled from a valid/ready source.
module i2c_target #(
    parameter logic [6:0] ADDRESS    = 7'b1010010,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_t,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       addressed,
    output logic       start_det,
    output logic       stop_det
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE
    } state_t;

    // bit 0 = SCL, bit 1 = SDA; idle bus level is high
    logic [1:0]      sy1_q, sy2_q, flt_q, prv_q;
    logic [1:0][3:0] fcnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sy1_q  <= '1;
            sy2_q  <= '1;
            flt_q  <= '1;
            prv_q  <= '1;
            fcnt_q <= '0;
        end else begin
            sy1_q <= {sda_i, scl_i};
            sy2_q <= sy1_q;
            prv_q <= flt_q;
            for (int i = 0; i < 2; i++) begin
                if (sy2_q[i] == flt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == 4'(FILTER_LEN - 1)) begin
                    flt_q[i]  <= sy2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 4'd1;
                end
            end
        end
    end

    logic scl_rise, scl_fall, start_c, stop_c, sda_f;
    assign sda_f    = flt_q[1];
    assign scl_rise = flt_q[0] & ~prv_q[0];
    assign scl_fall = ~flt_q[0] & prv_q[0];
    // SCL must be high both before and after the SDA edge, so a simultaneous
    // SCL/SDA fall (e.g. right after reset) is not taken as a START
    assign start_c  = flt_q[0] & prv_q[0] & prv_q[1] & ~flt_q[1];
    assign stop_c   = flt_q[0] & prv_q[0] & ~prv_q[1] & flt_q[1];

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [7:0] sh_q, tx_sh_q, rx_data_q;
    logic       rw_q, sda_t_q, rx_valid_q, rx_first_q, tx_ready_q;
    logic       busy_q, addr_q, start_q, stop_q;
    logic [7:0] load_byte;

    assign load_byte = tx_valid ? tx_data : 8'hFF;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            tx_sh_q    <= '0;
            rx_data_q  <= '0;
            rw_q       <= 1'b0;
            sda_t_q    <= 1'b1;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            addr_q     <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            if (start_c) begin
                state_q    <= ADDR;
                cnt_q      <= '0;
                sda_t_q    <= 1'b1;
                start_q    <= 1'b1;
                busy_q     <= 1'b1;
                addr_q     <= 1'b0;
                rx_first_q <= 1'b0;
            end else if (stop_c) begin
                state_q    <= IDLE;
                sda_t_q    <= 1'b1;
                stop_q     <= 1'b1;
                busy_q     <= 1'b0;
                addr_q     <= 1'b0;
                rx_first_q <= 1'b0;
            end else begin
                case (state_q)
                    ADDR, WRITE: begin
                        if (scl_rise) begin
                            sh_q  <= {sh_q[6:0], sda_f};
                            cnt_q <= cnt_q + 4'd1;
                        end else if (scl_fall && cnt_q == 4'd8) begin
                            if (state_q == WRITE) begin
                                rx_data_q  <= sh_q;
                                rx_valid_q <= 1'b1;
                                sda_t_q    <= 1'b0;
                                state_q    <= WRITE_ACK;
                            end else if (sh_q[7:1] == ADDRESS && sh_q[7:1] != 7'd0) begin
                                rw_q    <= sh_q[0];
                                sda_t_q <= 1'b0;
                                addr_q  <= 1'b1;
                                state_q <= ADDR_ACK;
                            end else begin
                                state_q <= IGNORE;
                            end
                        end
                    end
                    // Read-side byte load happens on the same fall that leaves the ACK state
                    ADDR_ACK, READ_ACK: begin
                        if (state_q == READ_ACK && scl_rise && sda_f) begin
                            addr_q  <= 1'b0;
                            state_q <= IGNORE;
                        end else if (scl_fall) begin
                            if (state_q == ADDR_ACK && !rw_q) begin
                                sda_t_q    <= 1'b1;
                                cnt_q      <= '0;
                                rx_first_q <= 1'b1;
                                state_q    <= WRITE;
                            end else begin
                                tx_sh_q    <= load_byte;
                                sda_t_q    <= load_byte[7];
                                tx_ready_q <= tx_valid;
                                cnt_q      <= 4'd1;
                                state_q    <= READ;
                            end
                        end
                    end
                    WRITE_ACK: begin
                        if (scl_fall) begin
                            sda_t_q    <= 1'b1;
                            cnt_q      <= '0;
                            rx_first_q <= 1'b0;
                            state_q    <= WRITE;
                        end
                    end
                    READ: begin
                        if (scl_fall) begin
                            if (cnt_q == 4'd8) begin
                                sda_t_q <= 1'b1;
                                state_q <= READ_ACK;
                            end else begin
                                sda_t_q <= tx_sh_q[6];
                                tx_sh_q <= {tx_sh_q[6:0], 1'b0};
                                cnt_q   <= cnt_q + 4'd1;
                            end
                        end
                    end
                    default: sda_t_q <= 1'b1;
                endcase
            end
        end
    end

    assign sda_o     = 1'b0;
    assign sda_t     = sda_t_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_first  = rx_first_q;
    assign tx_ready  = tx_ready_q;
    assign busy      = busy_q;
    assign addressed = addr_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C controller, rx/tx scoreboards and
// per-scenario tasks.
module tb_i2c_target;
    localparam int Q = 8;  // quarter SCL period in clk cycles

    logic       clk = 1'b0, rst = 1'b1, scl_drv = 1'b1, sda_drv = 1'b1;
    logic       sda_o, sda_t, rx_valid, rx_first, tx_ready, busy, addressed, start_det, stop_det;
    logic [7:0] rx_data;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       sda_line;

    assign sda_line = sda_drv & (sda_t | sda_o);
    always #5 clk = ~clk;

    i2c_target #(.ADDRESS(7'b1010010), .FILTER_LEN(3)) dut (
        .clk(clk), .rst(rst), .scl_i(scl_drv), .sda_i(sda_line),
        .sda_o(sda_o), .sda_t(sda_t), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_first(rx_first), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .addressed(addressed),
        .start_det(start_det), .stop_det(stop_det)
    );

    int checks = 0, passed = 0;
    int n_rx = 0, n_txr = 0, n_start = 0, n_stop = 0, guard_err = 0;
    logic       guard_rel = 1'b0;
    logic [8:0] rx_exp_q[$];   // {first, data}
    logic [7:0] tx_src_q[$];
    logic [7:0] rd_exp_q[$];

    // Byte source, event counters and rx scoreboard
    always @(negedge clk) begin
        if (tx_ready) begin
            n_txr++;
            if (tx_src_q.size() > 0) void'(tx_src_q.pop_front());
        end
        tx_valid = tx_src_q.size() > 0;
        tx_data  = tx_valid ? tx_src_q[0] : 8'h00;
        if (start_det) n_start++;
        if (stop_det) n_stop++;
        if (guard_rel && sda_t !== 1'b1) guard_err++;
        if (rx_valid) begin
            logic [8:0] e;
            n_rx++;
            checks++;
            if (rx_exp_q.size() == 0) begin
                $display("FAIL rx_unexpected got first=%b data=%h", rx_first, rx_data);
            end else begin
                e = rx_exp_q.pop_front();
                if ({rx_first, rx_data} !== e)
                    $display("FAIL rx_byte got first=%b data=%h want first=%b data=%h",
                             rx_first, rx_data, e[8], e[7:0]);
                else passed++;
            end
        end
    end

    task automatic qw();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        sda_drv = 1'b0; qw();
        scl_drv = 1'b0; qw();
    endtask

    task automatic bus_rstart();
        sda_drv = 1'b1; qw();
        scl_drv = 1'b1; qw();
        sda_drv = 1'b0; qw();
        scl_drv = 1'b0; qw();
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; qw();
        scl_drv = 1'b1; qw();
        sda_drv = 1'b1; qw();
        qw();
    endtask

    task automatic bus_bit(input logic b, output logic s);
        sda_drv = b;    qw();
        scl_drv = 1'b1; qw();
        s = sda_line;   qw();
        scl_drv = 1'b0; qw();
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, ack);
    endtask

    task automatic rd_byte(input logic ackbit, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(ackbit, s);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sda_t, sda_o, rx_data} !== {1'b1, 1'b0, 8'h00})
            $display("FAIL reset_data got sda_t=%b sda_o=%b rx_data=%h want 1 0 00", sda_t, sda_o, rx_data);
        else passed++;
        checks++;
        if ({rx_valid, rx_first, tx_ready, busy, addressed, start_det, stop_det} !== 7'b0)
            $display("FAIL reset_flags got %b want 0000000",
                     {rx_valid, rx_first, tx_ready, busy, addressed, start_det, stop_det});
        else passed++;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_write();
        logic a0, a1, a2;
        int rx0 = n_rx, st0 = n_stop;
        rx_exp_q.push_back({1'b1, 8'h3C});
        rx_exp_q.push_back({1'b0, 8'h81});
        bus_start();
        wr_byte(8'hA4, a0);
        checks++;
        if (addressed !== 1'b1) $display("FAIL wr_addressed got %b want 1", addressed); else passed++;
        wr_byte(8'h3C, a1);
        wr_byte(8'h81, a2);
        checks++;
        if ({a0, a1, a2} !== 3'b000) $display("FAIL wr_acks got %b want 000", {a0, a1, a2}); else passed++;
        bus_stop();
        checks++;
        if (n_rx - rx0 !== 2 || rx_exp_q.size() !== 0)
            $display("FAIL wr_rx_count got %0d want 2", n_rx - rx0);
        else passed++;
        checks++;
        if (n_stop - st0 !== 1 || busy !== 1'b0)
            $display("FAIL wr_stop got stops=%0d busy=%b want 1 0", n_stop - st0, busy);
        else passed++;
    endtask

    task automatic test_nack();
        logic a0, a1;
        int rx0 = n_rx;
        bus_start();
        wr_byte(8'hA6, a0);
        wr_byte(8'h55, a1);
        checks++;
        if ({a0, a1, addressed, busy} !== 4'b1101)
            $display("FAIL nack_state got ack=%b%b addressed=%b busy=%b want 11 0 1", a0, a1, addressed, busy);
        else passed++;
        bus_stop();
        checks++;
        if (busy !== 1'b0 || n_rx !== rx0)
            $display("FAIL nack_after_stop got busy=%b rx=%0d want 0 %0d", busy, n_rx, rx0);
        else passed++;
    endtask

    task automatic test_read();
        logic       a;
        logic [7:0] d0, d1, e0, e1;
        int tr0 = n_txr;
        tx_src_q.push_back(8'h5A); rd_exp_q.push_back(8'h5A);
        tx_src_q.push_back(8'hC3); rd_exp_q.push_back(8'hC3);
        bus_start();
        wr_byte(8'hA5, a);
        rd_byte(1'b0, d0);
        rd_byte(1'b1, d1);
        e0 = rd_exp_q.pop_front();
        e1 = rd_exp_q.pop_front();
        checks++;
        if ({a, d0, d1} !== {1'b0, e0, e1})
            $display("FAIL rd_bytes got ack=%b %h %h want 0 %h %h", a, d0, d1, e0, e1);
        else passed++;
        checks++;
        if (sda_t !== 1'b1 || addressed !== 1'b0)
            $display("FAIL rd_release got sda_t=%b addressed=%b want 1 0", sda_t, addressed);
        else passed++;
        bus_stop();
        checks++;
        if (n_txr - tr0 !== 2) $display("FAIL rd_tx_ready got %0d want 2", n_txr - tr0); else passed++;
    endtask

    task automatic test_read_empty();
        logic       a;
        logic [7:0] d;
        int tr0 = n_txr;
        bus_start();
        wr_byte(8'hA5, a);
        rd_byte(1'b1, d);
        bus_stop();
        checks++;
        if ({a, d} !== {1'b0, 8'hFF}) $display("FAIL rd_empty got ack=%b %h want 0 ff", a, d); else passed++;
        checks++;
        if (n_txr !== tr0) $display("FAIL rd_empty_ready got %0d want 0", n_txr - tr0); else passed++;
    endtask

    task automatic test_back_to_back();
        logic       a0, a1, a2;
        logic [7:0] d, e;
        int rx0 = n_rx, s0 = n_start, st0 = n_stop;
        rx_exp_q.push_back({1'b1, 8'h10});
        tx_src_q.push_back(8'h99); rd_exp_q.push_back(8'h99);
        bus_start();
        wr_byte(8'hA4, a0);
        wr_byte(8'h10, a1);
        bus_rstart();
        wr_byte(8'hA5, a2);
        rd_byte(1'b1, d);
        e = rd_exp_q.pop_front();
        checks++;
        if ({a0, a1, a2, d} !== {3'b000, e} || n_stop !== st0)
            $display("FAIL rstart_read got ack=%b%b%b %h stops=%0d want 000 %h 0", a0, a1, a2, d, n_stop - st0, e);
        else passed++;
        bus_stop();
        checks++;
        if (n_start - s0 !== 2 || n_rx - rx0 !== 1)
            $display("FAIL rstart_counts got starts=%0d rx=%0d want 2 1", n_start - s0, n_rx - rx0);
        else passed++;
    endtask

    task automatic test_abort_glitch();
        logic a, s;
        int rx0 = n_rx, s0;
        bus_start();
        wr_byte(8'hA4, a);
        bus_bit(1'b1, s); bus_bit(1'b0, s); bus_bit(1'b1, s); bus_bit(1'b0, s);
        bus_stop();
        checks++;
        if (n_rx !== rx0 || busy !== 1'b0)
            $display("FAIL abort_partial got rx=%0d busy=%b want 0 0", n_rx - rx0, busy);
        else passed++;
        s0 = n_start;
        @(posedge clk); #1 sda_drv = 1'b0;
        @(posedge clk); #1 sda_drv = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (n_start !== s0 || busy !== 1'b0)
            $display("FAIL glitch_start got starts=%0d busy=%b want 0 0", n_start - s0, busy);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic a, s;
        tx_src_q.push_back(8'h00);
        bus_start();
        wr_byte(8'hA5, a);
        bus_bit(1'b1, s); bus_bit(1'b1, s); bus_bit(1'b1, s);
        checks++;
        if (sda_t !== 1'b0) $display("FAIL rst_pre_drive got sda_t=%b want 0", sda_t); else passed++;
        rst = 1'b1;
        #1;
        checks++;
        if (sda_t !== 1'b1) $display("FAIL rst_release got sda_t=%b want 1", sda_t); else passed++;
        guard_rel = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) bus_bit(1'b1, s);
        bus_bit(1'b0, s);
        bus_stop();
        guard_rel = 1'b0;
        checks++;
        if (guard_err !== 0 || busy !== 1'b0 || addressed !== 1'b0)
            $display("FAIL rst_stay_idle got drives=%0d busy=%b addressed=%b want 0 0 0", guard_err, busy, addressed);
        else passed++;
        bus_start();
        wr_byte(8'hA4, a);
        bus_stop();
        checks++;
        if (a !== 1'b0) $display("FAIL rst_recover got ack=%b want 0", a); else passed++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_nack();
        test_read();
        test_read_empty();
        test_back_to_back();
        test_abort_glitch();
        test_reset_mid();
        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
